// File: rtl/booth_mult_ctrl.sv
// Control sequencer for a radix-2 Booth signed multiplier built from A/Q/M shift registers.
// It emits the datapath strobes, counts iterations, and reads out A and then Q onto the output bus.
module booth_mult_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q0,
  input  logic             q_minus1,
  output logic             busy,
  output logic             load_m,
  output logic             load_q,
  output logic             clear_a,
  output logic             load_a,
  output logic             add_sub,
  output logic             shift_enable,
  output logic             out_a,
  output logic             out_q,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_M = 3'd1;
  localparam logic [2:0] S_LOAD_Q = 3'd2;
  localparam logic [2:0] S_TEST   = 3'd3;
  localparam logic [2:0] S_ADDSUB = 3'd4;
  localparam logic [2:0] S_SHIFT  = 3'd5;
  localparam logic [2:0] S_OUT_A  = 3'd6;
  localparam logic [2:0] S_OUT_Q  = 3'd7;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_M;
      end
      S_LOAD_M: state_d = S_LOAD_Q;
      S_LOAD_Q: begin
        cnt_d   = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        // 10 -> subtract, 01 -> add; equal bits need only the shift
        if (q0 ^ q_minus1) begin
          op_d    = q0;
          state_d = S_ADDSUB;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADDSUB: state_d = S_SHIFT;
      S_SHIFT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST_ITER) ? S_OUT_A : S_TEST;
      end
      S_OUT_A: state_d = S_OUT_Q;
      S_OUT_Q: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Every strobe is decoded from registered state, so the asynchronous reset clears them at once
  always_comb begin
    busy         = (state_q != S_IDLE);
    load_m       = (state_q == S_LOAD_M);
    load_q       = (state_q == S_LOAD_Q);
    clear_a      = (state_q == S_LOAD_Q);
    load_a       = (state_q == S_ADDSUB);
    add_sub      = (state_q == S_ADDSUB) & op_q;
    shift_enable = (state_q == S_SHIFT);
    out_a        = (state_q == S_OUT_A);
    out_q        = (state_q == S_OUT_Q);
    done         = (state_q == S_OUT_Q);
  end

  assign iter_cnt = cnt_q;

endmodule
